// File: rtl/bram_framebuffer_db_if.sv
// bram_framebuffer_db_if: pixel write, pixel read and front/back buffer control bundle
interface bram_framebuffer_db_if #(
    parameter int W_BITS = 7,
    parameter int H_BITS = 7,
    parameter int C_R = 4,
    parameter int C_G = 4,
    parameter int C_B = 4,
    parameter int O_R = 5,
    parameter int O_G = 6,
    parameter int O_B = 5
);
    logic wr_en;
    logic [W_BITS-1:0] wr_x;
    logic [H_BITS-1:0] wr_y;
    logic [C_R+C_G+C_B-1:0] wr_data;
    logic wr_ready;
    logic rd_en;
    logic [W_BITS-1:0] col;
    logic [H_BITS-1:0] row;
    logic [O_R-1:0] r;
    logic [O_G-1:0] g;
    logic [O_B-1:0] b;
    logic rd_valid;
    logic frame_start;
    logic swap_req;
    logic swap_pending;
    logic front_sel;
    logic clear_req;
    logic busy;
    logic clear_done;
    modport master (
        output wr_en, wr_x, wr_y, wr_data, rd_en, col, row, frame_start, swap_req, clear_req,
        input wr_ready, r, g, b, rd_valid, swap_pending, front_sel, busy, clear_done
    );
    modport slave (
        input wr_en, wr_x, wr_y, wr_data, rd_en, col, row, frame_start, swap_req, clear_req,
        output wr_ready, r, g, b, rd_valid, swap_pending, front_sel, busy, clear_done
    );
endinterface

// File: rtl/bram_framebuffer_db.sv
// bram_framebuffer_db: double-buffered BRAM framebuffer with frame-synchronous swap and back-buffer clear
module bram_framebuffer_db #(
    parameter int W_BITS = 7,
    parameter int H_BITS = 7,
    parameter int C_R = 4,
    parameter int C_G = 4,
    parameter int C_B = 4,
    parameter int O_R = 5,
    parameter int O_G = 6,
    parameter int O_B = 5,
    parameter logic [C_R+C_G+C_B-1:0] CLEAR_COLOR = '0
) (
    input logic clk,
    input logic reset,
    bram_framebuffer_db_if.slave bus
);
    localparam int AW = W_BITS + H_BITS;
    localparam int DW = C_R + C_G + C_B;
    localparam int DEPTH = 1 << AW;
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, state_n;
    logic [AW-1:0] cnt, cnt_n, waddr, raddr;
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] wdata, q0, q1, q;
    logic [O_R-1:0] r_x;
    logic [O_G-1:0] g_x;
    logic [O_B-1:0] b_x;
    logic we, do_swap, front, pending, rv_q, sel_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = '0;
        bus.clear_done = 1'b0;
        bus.busy = state == CLEAR;
        bus.wr_ready = state == IDLE;
        if (state == IDLE) begin
            state_n = bus.clear_req ? CLEAR : IDLE;
        end else begin
            cnt_n = cnt + AW'(1);
            bus.clear_done = &cnt;
            state_n = &cnt ? IDLE : CLEAR;
        end
    end
    // memory is never touched while reset is held, so an aborted clear leaves a partial fill
    assign we = reset && (state == CLEAR || bus.wr_en);
    assign waddr = state == CLEAR ? cnt : {bus.wr_y, bus.wr_x};
    assign wdata = state == CLEAR ? CLEAR_COLOR : bus.wr_data;
    assign raddr = {bus.row, bus.col};
    always_ff @(posedge clk) begin
        if (we && front) mem0[waddr] <= wdata;
        if (we && !front) mem1[waddr] <= wdata;
        q0 <= mem0[raddr];
        q1 <= mem1[raddr];
        sel_q <= front;
    end
    assign q = sel_q ? q1 : q0;
    for (genvar i = 0; i < O_R; i++) begin : g_r
        assign r_x[O_R-1-i] = q[DW-1-(i % C_R)];
    end
    for (genvar i = 0; i < O_G; i++) begin : g_g
        assign g_x[O_G-1-i] = q[C_G+C_B-1-(i % C_G)];
    end
    for (genvar i = 0; i < O_B; i++) begin : g_b
        assign b_x[O_B-1-i] = q[C_B-1-(i % C_B)];
    end
    assign do_swap = state == IDLE && bus.frame_start && (pending || bus.swap_req);
    always_ff @(posedge clk) begin
        if (!reset) begin
            front <= 1'b0;
            pending <= 1'b0;
            rv_q <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.r <= '0;
            bus.g <= '0;
            bus.b <= '0;
        end else begin
            front <= front ^ do_swap;
            pending <= !do_swap && (pending || bus.swap_req);
            rv_q <= bus.rd_en;
            bus.rd_valid <= rv_q;
            if (rv_q) begin
                bus.r <= r_x;
                bus.g <= g_x;
                bus.b <= b_x;
            end
        end
    end
    assign bus.front_sel = front;
    assign bus.swap_pending = pending;
endmodule
